// File: rtl/mdu_multi_if.sv
// Bus bundle between the E stage and the multiply/divide unit.
// The stage is the master; the MDU is the slave.
interface mdu_multi_if #(
  parameter int WIDTH = 32
) ();

  // Launch protocol: start_i with op_i is accepted only in a cycle where busy_o=0 and
  // flush_i=0. real_busy_o already counts a long op being launched this cycle, so the
  // stall logic can hold dependent instructions. done_o pulses once for each commit
  // (and for a divide by zero); flush_i drops the operation in flight without a commit.
  logic             start_i;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] d1_i;
  logic [WIDTH-1:0] d2_i;
  logic             flush_i;
  logic             rd_hi_i;
  logic             busy_o;
  logic             real_busy_o;
  logic             done_o;
  logic             div_zero_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic [WIDTH-1:0] mdu_out_o;
  logic [0:0]       state_o;

  modport master (
    output start_i, op_i, d1_i, d2_i, flush_i, rd_hi_i,
    input  busy_o, real_busy_o, done_o, div_zero_o, hi_o, lo_o, mdu_out_o, state_o
  );

  modport slave (
    input  start_i, op_i, d1_i, d2_i, flush_i, rd_hi_i,
    output busy_o, real_busy_o, done_o, div_zero_o, hi_o, lo_o, mdu_out_o, state_o
  );

endinterface

// File: rtl/mdu_multi.sv
// Multi-cycle multiply/divide unit with HI/LO registers, multiply-accumulate,
// flush and an early exit on divide by zero.
module mdu_multi #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_multi_if.slave  bus
);

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MADD  = 4'd4;
  localparam logic [3:0] OP_MADDU = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MSUBU = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Multiply datapath: operands extended to 2*WIDTH so one product serves signed and unsigned.
  logic               mul_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc, mul_res;

  assign mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
  assign ext_a = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign ext_b = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod  = ext_a * ext_b;
  assign acc   = {hi_q, lo_q};

  always_comb begin
    mul_res = prod;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = acc + prod;
      OP_MSUB, OP_MSUBU: mul_res = acc - prod;
      default:           mul_res = prod;
    endcase
  end

  // Divide on magnitudes, then restore signs; -2^(W-1)/-1 falls out as -2^(W-1) rem 0.
  logic             div_signed, is_div;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  assign is_div     = (op_q == OP_DIV) || (op_q == OP_DIVU);
  assign div_signed = (op_q == OP_DIV);
  assign a_neg      = div_signed & a_q[WIDTH-1];
  assign b_neg      = div_signed & b_q[WIDTH-1];
  assign a_mag      = a_neg ? -a_q : a_q;
  assign b_mag      = b_neg ? -b_q : b_q;
  assign b_safe     = (b_mag == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
  assign q_mag      = a_mag / b_safe;
  assign r_mag      = a_mag % b_safe;
  assign quot       = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem        = a_neg ? -r_mag : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          case (bus.op_i)
            OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              op_d    = bus.op_i;
              a_d     = bus.d1_i;
              b_d     = bus.d2_i;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              if (bus.d2_i == '0) begin
                dz_d   = 1'b1;
                done_d = 1'b1;
              end else begin
                op_d    = bus.op_i;
                a_d     = bus.d1_i;
                b_d     = bus.d2_i;
                cnt_d   = CNT_W'(DIV_CYCLES);
                state_d = S_RUN;
              end
            end
            OP_MTHI: hi_d = bus.d1_i;
            OP_MTLO: lo_d = bus.d1_i;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        if (bus.flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          if (is_div) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            {hi_d, lo_d} = mul_res;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy_o      = (state_q == S_RUN);
  assign bus.real_busy_o = (state_q == S_RUN) | (bus.start_i & ~bus.op_i[3]);
  assign bus.done_o      = done_q;
  assign bus.div_zero_o  = dz_q;
  assign bus.hi_o        = hi_q;
  assign bus.lo_o        = lo_q;
  assign bus.mdu_out_o   = bus.rd_hi_i ? hi_q : lo_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_mdu_multi.sv
// Randomised scoreboard bench for mdu_multi: a behavioural HI/LO model predicts
// every commit and a monitor checks each done pulse against the queued prediction.
module tb_mdu_multi;

  localparam int W  = 32;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  mdu_multi_if #(.WIDTH(W)) bus ();

  mdu_multi #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W:0] exp_q[$];
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit integer arithmetic on the architectural HI/LO pair.
  task automatic model_apply(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint     sa, sb, sq, sr;
    logic [63:0] ua, ub, acc, p;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    acc = {m_hi, m_lo};
    case (op)
      4'd0: {m_hi, m_lo} = 64'(sa * sb);
      4'd1: {m_hi, m_lo} = ua * ub;
      4'd4: begin p = 64'(sa * sb); {m_hi, m_lo} = acc + p; end
      4'd5: {m_hi, m_lo} = acc + ua * ub;
      4'd6: begin p = 64'(sa * sb); {m_hi, m_lo} = acc - p; end
      4'd7: {m_hi, m_lo} = acc - ua * ub;
      4'd2: begin
        if (b == '0) m_dz = 1'b1;
        else begin
          sq = sa / sb;
          sr = sa % sb;
          m_lo = sq[31:0];
          m_hi = sr[31:0];
        end
      end
      4'd3: begin
        if (b == '0) m_dz = 1'b1;
        else begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      4'd8: m_hi = a;
      4'd9: m_lo = a;
      default: ;
    endcase
    if (op < 4'd8) exp_q.push_back({m_hi, m_lo, m_dz});
  endtask

  // Monitor: every done pulse must match the oldest prediction.
  always @(negedge clk) begin
    if (reset && bus.done_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no commit (hi=%0h lo=%0h)", bus.hi_o, bus.lo_o);
      end else begin
        check("commit", {bus.hi_o, bus.lo_o, bus.div_zero_o}, exp_q.pop_front());
      end
    end
  end

  // Drivers
  task automatic idle_inputs();
    bus.start_i = 1'b0;
    bus.op_i    = '0;
    bus.d1_i    = '0;
    bus.d2_i    = '0;
    bus.flush_i = 1'b0;
    bus.rd_hi_i = 1'b0;
  endtask

  function automatic int lat_of(input logic [3:0] op, input logic [W-1:0] b);
    if (op <= 4'd1 || (op >= 4'd4 && op <= 4'd7)) return MC;
    if ((op == 4'd2 || op == 4'd3) && b != '0) return DC;
    return 0;
  endfunction

  // Called just after a rising edge; poke>0 drives a stray start in that busy cycle.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int poke);
    int exp_busy;
    int cnt;
    exp_busy = lat_of(op, b);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.d1_i    = a;
    bus.d2_i    = b;
    #1;
    check("real_busy", bus.real_busy_o, (op < 4'd8));
    model_apply(op, a, b);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    cnt = 0;
    while (bus.busy_o && cnt < 200) begin
      cnt++;
      if (cnt == poke) begin
        bus.start_i = 1'b1;
        bus.op_i    = 4'($urandom_range(0, 9));
        bus.d1_i    = $urandom;
        bus.d2_i    = $urandom;
      end else begin
        bus.start_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    bus.start_i = 1'b0;
    check("busy_cycles", cnt, exp_busy);
    check("done_pulse", bus.done_o, (op < 4'd8));
    bus.rd_hi_i = 1'($urandom_range(0, 1));
    #1;
    check("mdu_out", bus.mdu_out_o, bus.rd_hi_i ? m_hi : m_lo);
  endtask

  task automatic do_flush(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.d1_i    = a;
    bus.d2_i    = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (k - 1) begin @(posedge clk); #1; end
    bus.flush_i = 1'b1;
    @(posedge clk); #1;
    bus.flush_i = 1'b0;
    check("flush_busy", bus.busy_o, 1'b0);
    check("flush_no_done", bus.done_o, 1'b0);
    check("flush_hilo", {bus.hi_o, bus.lo_o, bus.div_zero_o}, {m_hi, m_lo, m_dz});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, '0);
    check({tag, "_flags"}, {bus.busy_o, bus.done_o, bus.div_zero_o, bus.state_o}, '0);
    check({tag, "_mdu_out"}, bus.mdu_out_o, '0);
  endtask

  // Main sequence
  initial begin
    logic [3:0] op;
    logic [W-1:0] a, b;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_hold");
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check_reset_values("reset_release");

    do_op(4'd0, 32'hFFFF_FFFE, 32'd3, 0);
    check("mult_const", {bus.hi_o, bus.lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    do_op(4'd1, 32'hFFFF_FFFE, 32'd3, 0);
    check("multu_const", {bus.hi_o, bus.lo_o}, {32'h0000_0002, 32'hFFFF_FFFA});
    do_op(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("maddu_lo", bus.lo_o, 32'hFFFF_FFFB);
    do_op(4'd2, 32'hFFFF_FFF9, 32'd2, 0);
    check("div_neg7_2", {bus.hi_o, bus.lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    check("div_overflow", {bus.hi_o, bus.lo_o}, {32'h0, 32'h8000_0000});
    do_op(4'd8, 32'd5, 32'd0, 0);
    do_op(4'd9, 32'd6, 32'd0, 0);
    do_op(4'd3, 32'd77, 32'd0, 0);
    check("divu_zero", {bus.hi_o, bus.lo_o, bus.div_zero_o}, {32'd5, 32'd6, 1'b1});

    do_flush(4'd0, 32'd1234, 32'd99, 3);
    bus.start_i = 1'b1; bus.op_i = 4'd8; bus.d1_i = 32'h1234; bus.flush_i = 1'b1;
    @(posedge clk); #1;
    idle_inputs();
    check("flush_mthi", bus.hi_o, m_hi);

    do_op(4'd0, $urandom, $urandom, 2);
    do_op(4'd6, $urandom, $urandom, MC);

    // Reset in DIV busy cycle 4 clears everything asynchronously.
    bus.start_i = 1'b1; bus.op_i = 4'd2; bus.d1_i = 32'd1000; bus.d2_i = 32'd7;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b0;
    #1;
    check_reset_values("reset_midrun");
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op > 4'd9 && $urandom_range(0, 2) != 0) op = 4'($urandom_range(0, 9));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? '0 : $urandom;
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 0) do_flush(4'($urandom_range(0, 1)), a, b, $urandom_range(1, MC - 1));
        else do_flush(4'($urandom_range(2, 3)), a, (b == '0) ? 32'd1 : b, $urandom_range(1, DC - 1));
      end else begin
        do_op(op, a, b, $urandom_range(0, 4));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
